// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encoding, FSM state encoding and status-register layout
// shared by alu_sequencer and alu_seq_flags.
// Optional feature macro: ALU_SEQ_CMP_EN (makes op_code 9 a legal CMP).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADC = 4'd0,
    OP_SBC = 4'd1,
    OP_AND = 4'd2,
    OP_EOR = 4'd3,
    OP_ORA = 4'd4,
    OP_ASL = 4'd5,
    OP_LSR = 4'd6,
    OP_ROL = 4'd7,
    OP_ROR = 4'd8,
    OP_CMP = 4'd9
  } op_code_e;

  // Sequencer state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_EXEC  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Status register bit positions: {N,V,1,0,0,0,Z,C}
  localparam int SR_N = 7;
  localparam int SR_V = 6;
  localparam int SR_Z = 1;
  localparam int SR_C = 0;
  localparam logic [7:0] STATUS_RST = 8'h20;

  function automatic logic op_is_legal(input logic [3:0] code);
`ifdef ALU_SEQ_CMP_EN
    return (code <= 4'd9);
`else
    return (code <= 4'd8);
`endif
  endfunction

  function automatic logic op_is_shift(input logic [3:0] code);
    return (code >= 4'd5) && (code <= 4'd8);
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// alu_seq_flags: combinational ISA-level flag computation and result
// correction for one executing instruction. Rotates take their result from
// the local computation so C always enters at the correct end; CMP builds its
// own difference because the ALU is driven with carry-in 0 for it.
// Optional feature macro: ALU_SEQ_CMP_EN (adds the CMP flag path).
module alu_seq_flags
  import alu_seq_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [3:0]   op_code,
  input  logic         op_mem,
  input  logic [n-1:0] acc,
  input  logic [n-1:0] operand,
  input  logic         c_in,
  input  logic         v_in,
  input  logic [n-1:0] alu_out,
  input  logic         alu_overflow,
  output logic [n-1:0] result,
  output logic [7:0]   status_out,
  output logic         acc_we
);

  logic [n-1:0] src;
  logic         adc_c;
  logic         sbc_c;
  logic         sbc_v;
  logic         v_new;
  logic         c_new;

  // Shifts act on the fetched operand for memory targets, on acc otherwise
  assign src   = op_mem ? operand : acc;
  assign adc_c = ({1'b0, acc} + {1'b0, operand} + {{n{1'b0}}, c_in}) > {1'b0, {n{1'b1}}};
  assign sbc_c = {1'b0, acc} >= ({1'b0, operand} + {{n{1'b0}}, ~c_in});
  assign sbc_v = (acc[n-1] ^ operand[n-1]) & (acc[n-1] ^ alu_out[n-1]);

`ifdef ALU_SEQ_CMP_EN
  logic [n-1:0] cmp_res;
  logic         cmp_c;
  assign cmp_res = acc - operand;
  assign cmp_c   = acc >= operand;
`endif

  // Select result, V, C and destination per opcode, then pack the status byte
  always_comb begin
    result = alu_out;
    v_new  = v_in;
    c_new  = c_in;
    acc_we = 1'b1;
    case (op_code)
      OP_ADC: begin
        v_new = alu_overflow;
        c_new = adc_c;
      end
      OP_SBC: begin
        v_new = sbc_v;
        c_new = sbc_c;
      end
      OP_AND, OP_EOR, OP_ORA: begin
        acc_we = 1'b1;
      end
      OP_ASL: begin
        c_new  = src[n-1];
        acc_we = ~op_mem;
      end
      OP_LSR: begin
        c_new  = src[0];
        acc_we = ~op_mem;
      end
      OP_ROL: begin
        result = {src[n-2:0], c_in};
        c_new  = src[n-1];
        acc_we = ~op_mem;
      end
      OP_ROR: begin
        result = {c_in, src[n-1:1]};
        c_new  = src[0];
        acc_we = ~op_mem;
      end
`ifdef ALU_SEQ_CMP_EN
      OP_CMP: begin
        result = cmp_res;
        c_new  = cmp_c;
        acc_we = 1'b0;
      end
`endif
      default: begin
        acc_we = 1'b0;
      end
    endcase
    status_out       = STATUS_RST;
    status_out[SR_N] = result[n-1];
    status_out[SR_V] = v_new;
    status_out[SR_Z] = (result == '0);
    status_out[SR_C] = c_new;
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller between the instruction decoder and
// the 8-bit ALU / data-memory port. Accepts one instruction per handshake,
// optionally fetches a memory operand, runs one ALU cycle, writes back to acc
// or memory and updates the {N,V,1,0,0,0,Z,C} status register.
// Optional feature macro: ALU_SEQ_CMP_EN (op_code 9 = CMP; illegal otherwise).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op_code,
  input  logic         op_mem,
  input  logic [15:0]  op_addr,
  input  logic [n-1:0] op_imm,
  input  logic         acc_ld,
  input  logic [n-1:0] acc_ld_data,
  output logic [15:0]  mem_addr,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_mem,
  output logic         alu_subtract,
  output logic         alu_target_bus,
  output logic         alu_carry_in,
  output logic         alu_sum_sel,
  output logic         alu_and_sel,
  output logic         alu_xor_sel,
  output logic         alu_or_sel,
  output logic         alu_asl_sel,
  output logic         alu_lsr_sel,
  output logic         alu_rol_sel,
  output logic         alu_ror_sel,
  input  logic [n-1:0] alu_out,
  input  logic         alu_overflow,
  input  logic         alu_carry,
  input  logic         alu_zero,
  input  logic         alu_negative,
  output logic [n-1:0] acc,
  output logic [7:0]   status,
  output logic         done
);

  state_t       state;
  logic [3:0]   code_r;
  logic         mem_r;
  logic [15:0]  addr_r;
  logic [n-1:0] operand_r;
  logic [n-1:0] result_r;

  logic         accept;
  logic         legal;
  logic         shift_op;
  logic         in_exec;
  logic [n-1:0] fl_result;
  logic [7:0]   fl_status;
  logic         fl_acc_we;

  // Flags are recomputed at ISA level; the ALU's own C/Z/N are not consumed
  logic unused_alu_flags;
  assign unused_alu_flags = alu_carry ^ alu_zero ^ alu_negative;

  assign op_ready = (state == ST_IDLE) & ~acc_ld & ~rst;
  assign accept   = op_valid & op_ready;
  assign legal    = op_is_legal(op_code);
  assign shift_op = op_is_shift(code_r);
  assign in_exec  = (state == ST_EXEC);

  assign mem_rd    = (state == ST_FETCH);
  assign mem_wr    = (state == ST_WRITE);
  assign mem_addr  = (mem_rd | mem_wr) ? addr_r : 16'h0000;
  assign mem_wdata = mem_wr ? result_r : '0;
  assign done      = (state == ST_DONE);

  // Control FSM: IDLE -> [FETCH] -> EXEC -> [WRITE] -> DONE, illegal ops skip to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!legal)      state <= ST_DONE;
            else if (op_mem) state <= ST_FETCH;
            else             state <= ST_EXEC;
          end
        end
        ST_FETCH: if (mem_ack) state <= ST_EXEC;
        ST_EXEC:  state <= (shift_op && mem_r) ? ST_WRITE : ST_DONE;
        ST_WRITE: if (mem_ack) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Instruction capture at accept, memory operand at fetch ack, result at EXEC
  always_ff @(posedge clk) begin
    if (accept) begin
      code_r    <= op_code;
      mem_r     <= op_mem;
      addr_r    <= op_addr;
      operand_r <= op_imm;
    end else if ((state == ST_FETCH) && mem_ack) begin
      operand_r <= mem_rdata;
    end
    if (in_exec) result_r <= fl_result;
  end

  // Architectural acc/status: direct load in IDLE, write-back on the EXEC edge
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      status <= STATUS_RST;
    end else if ((state == ST_IDLE) && acc_ld) begin
      acc <= acc_ld_data;
    end else if (in_exec) begin
      status <= fl_status;
      if (fl_acc_we) acc <= fl_result;
    end
  end

  // ALU operand/select drive, active only during EXEC
  always_comb begin
    alu_a          = '0;
    alu_mem        = '0;
    alu_subtract   = 1'b0;
    alu_target_bus = 1'b0;
    alu_carry_in   = 1'b0;
    alu_sum_sel    = 1'b0;
    alu_and_sel    = 1'b0;
    alu_xor_sel    = 1'b0;
    alu_or_sel     = 1'b0;
    alu_asl_sel    = 1'b0;
    alu_lsr_sel    = 1'b0;
    alu_rol_sel    = 1'b0;
    alu_ror_sel    = 1'b0;
    if (in_exec) begin
      alu_a   = acc;
      alu_mem = operand_r;
      case (code_r)
        OP_ADC: begin
          alu_sum_sel  = 1'b1;
          alu_carry_in = status[SR_C];
        end
        OP_SBC: begin
          alu_sum_sel  = 1'b1;
          alu_subtract = 1'b1;
          alu_carry_in = status[SR_C];
        end
        OP_AND: alu_and_sel = 1'b1;
        OP_EOR: alu_xor_sel = 1'b1;
        OP_ORA: alu_or_sel  = 1'b1;
        OP_ASL: begin
          alu_asl_sel    = 1'b1;
          alu_target_bus = mem_r;
        end
        OP_LSR: begin
          alu_lsr_sel    = 1'b1;
          alu_target_bus = mem_r;
        end
        OP_ROL: begin
          alu_rol_sel    = 1'b1;
          alu_target_bus = mem_r;
          alu_carry_in   = status[SR_C];
        end
        OP_ROR: begin
          alu_ror_sel    = 1'b1;
          alu_target_bus = mem_r;
          alu_carry_in   = status[SR_C];
        end
`ifdef ALU_SEQ_CMP_EN
        OP_CMP: begin
          alu_sum_sel  = 1'b1;
          alu_subtract = 1'b1;
        end
`endif
        default: begin
          alu_sum_sel = 1'b0;
        end
      endcase
    end
  end

  alu_seq_flags #(
    .n (n)
  ) u_flags (
    .op_code      (code_r),
    .op_mem       (mem_r),
    .acc          (acc),
    .operand      (operand_r),
    .c_in         (status[SR_C]),
    .v_in         (status[SR_V]),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .result       (fl_result),
    .status_out   (fl_status),
    .acc_we       (fl_acc_we)
  );

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that drives the 8-bit ALU's operand and select inputs and consumes its result and flag outputs. It accepts one ALU instruction at a time over a valid/ready handshake and fetches a memory operand when needed. It executes the instruction through the ALU, writes the result back to the accumulator or to memory, and updates the processor status register. It sits between the instruction decoder and the ALU/data-memory port.

## Interface
- `n`, 8, datapath width (only 8 supported)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous and active-high
- `op_valid` in 1, `op_ready` out 1: instruction handshake
- `op_code` in 4: operation; ADC=0, SBC=1, AND=2, EOR=3, ORA=4, ASL=5, LSR=6, ROL=7, ROR=8, CMP=9 (CMP exists only with the macro defined)
- `op_mem` in 1: 0 = immediate operand (ADC..ORA) or shift A (ASL..ROR); 1 = memory operand or memory target
- `op_addr` in 16, `op_imm` in 8: memory address and immediate operand, captured at accept
- `acc_ld` in 1, `acc_ld_data` in 8: direct accumulator load
- `mem_addr` out 16, `mem_rd` out 1, `mem_wr` out 1, `mem_wdata` out 8, `mem_rdata` in 8, `mem_ack` in 1
- `alu_a` out 8, `alu_mem` out 8, `alu_subtract`, `alu_target_bus`, `alu_carry_in` out 1 each
- `alu_sum_sel`, `alu_and_sel`, `alu_xor_sel`, `alu_or_sel`, `alu_asl_sel`, `alu_lsr_sel`, `alu_rol_sel`, `alu_ror_sel` out 1 each
- `alu_out` in 8; `alu_overflow`, `alu_carry`, `alu_zero`, `alu_negative` in 1 each
- `acc` out 8, `status` out 8 as {N,V,1,0,0,0,Z,C}, `done` out 1

## Operation
- States: IDLE, FETCH, EXEC, WRITE, DONE.
- IDLE: `op_ready` = ~`acc_ld`. `acc_ld` loads `acc` and leaves flags unchanged.
- On accept, `op_code`, `op_mem`, `op_addr` and `op_imm` are registered.
  - Legal op with `op_mem`=1 → FETCH.
  - Legal op with `op_mem`=0 → EXEC.
  - Illegal op → DONE, with no state change.
- FETCH: holds `mem_rd`=1 and `mem_addr` stable. On the `mem_ack` cycle it captures `mem_rdata` into the operand register → EXEC.
- EXEC (exactly one cycle):
  - Drives `alu_a`=`acc`, `alu_mem`=operand, exactly one select, and `alu_target_bus`=`op_mem` for shifts.
  - `alu_subtract`=1 for SBC and CMP.
  - `alu_carry_in` = C for ADC, SBC, ROL and ROR; 0 otherwise.
  - Latches `alu_out` and the flags at the clock edge.
  - Shift with `op_mem`=1 → WRITE. Everything else → DONE.
- WRITE: holds `mem_wr`=1, `mem_addr`, and `mem_wdata`=result until `mem_ack` → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Destination:
  - ADC, SBC, AND, EOR, ORA and shifts with `op_mem`=0 write `acc`.
  - Shifts with `op_mem`=1 write memory only.
  - CMP writes nothing.
- Flags, computed at ISA level inside the sequencer (ALU flags are used only where listed):
  - N, Z always from the 8-bit result, for every op.
  - ADC: V from `alu_overflow`; C = bit 8 of `acc` + operand + C.
  - SBC: V = (`acc`^operand)&(`acc`^result) bit 7; C = 1 iff `acc` ≥ operand + ~C (no borrow).
  - CMP: C = `acc` ≥ operand; V unchanged.
  - AND, EOR, ORA: N, Z only.
  - ASL, ROL: C = old bit 7. LSR, ROR: C = old bit 0.
  - Result of ROL/ROR rotates C into bit 0/bit 7. The sequencer overrides `alu_out` with its own computation if it differs.
- `mem_rd` and `mem_wr` are never asserted together. `mem_ack` outside FETCH/WRITE is ignored.

## Timing
- Reset: state IDLE, `acc`=0x00, `status`=0x20, and every other output 0 (`op_ready`=1 from the cycle after reset deasserts).
- Reset mid-operation aborts at the next edge. `mem_rd`/`mem_wr` drop, and no write-back occurs.
- Latency from accept edge to `done`:
  - register/immediate op: 2 cycles;
  - memory op: 3 + fetch wait cycles;
  - memory shift: 4 + fetch wait + write wait cycles.
- `acc` and `status` update on the EXEC→next edge. They are visible in DONE.
- Back-to-back throughput: the next accept is possible the cycle after DONE.

## Configuration
- `ALU_SEQ_CMP_EN` defined: `op_code` 9 = CMP (subtract, flags N/Z/C, no destination).
- `ALU_SEQ_CMP_EN` undefined: 9 is illegal and goes IDLE→DONE with no state change. Opcodes 10–15 are always illegal.

## Structure
- `alu_seq_pkg` holds:
  - the `op_code` enum;
  - the state enum;
  - status bit index constants (N=7, V=6, Z=1, C=0) and the reset constant 0x20.
- One sub-module, `alu_seq_flags`: combinational flag/result-correction logic from the op, `acc`, operand, old C and the ALU outputs. The ALU itself is instantiated by the parent, not here.

## Test plan
- `acc_ld` 0x50, C=0, ADC imm 0x50 → `acc`=0xA0, N=1 V=1 Z=0 C=0, `done` 2 cycles after accept.
- `acc`=0x50, C=1, SBC imm 0xF0 → `acc`=0x60, N=0 V=0 Z=0 C=0.
- ROL mem 0x0200 holding 0x80, C=0, `mem_ack` 3 cycles late → write 0x00 to 0x0200, Z=1 C=1, `acc` unchanged, no overlap of `mem_rd`/`mem_wr`.
- `acc`=0x01, LSR A → `acc`=0x00, Z=1 C=1 N=0.
- `rst` pulsed while in FETCH → `mem_rd`=0 next cycle, no `mem_wr` ever, `acc`=0x00, `status`=0x20.
- `acc`=0x10, op 9 imm 0x10 → with macro: Z=1 C=1, `acc`=0x10; without macro: `done` 1 cycle after accept, `status` unchanged.
